// File: rtl/alarm_pkg.sv
// Shared state encoding and countdown width for the alarm sequencer.
package alarm_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_SIREN    = 3'd4
    } state_t;

    // States whose duration is governed by the countdown.
    function automatic logic is_timed(input state_t s);
        return (s == ST_EXIT) || (s == ST_ENTRY) || (s == ST_SIREN);
    endfunction

    // States in which the status LED blinks once per tick.
    function automatic logic is_blink(input state_t s);
        return (s == ST_EXIT) || (s == ST_ENTRY);
    endfunction

endpackage

// File: rtl/alarm_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks; restarts on clear.
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_pre;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_pre <= '0;
        end else if (r_pre == LAST) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    assign o_tick = (r_pre == LAST);

endmodule

// File: rtl/alarm_sequencer.sv
// Arming/alarm controller: synchronizes the switches and sequences
// DISARMED -> EXIT -> ARMED -> ENTRY -> SIREN with tick-based countdowns.
module alarm_sequencer #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int EXIT_TICKS  = 10,
    parameter int ENTRY_TICKS = 5,
    parameter int SIREN_TICKS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arm,
    input  logic [3:0] sensor,
    output logic       siren,
    output logic       led,
    output logic [2:0] state_code,
    output logic [7:0] remaining,
    output logic [3:0] zone
);
    import alarm_pkg::*;

    localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_TICKS);
    localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_TICKS);
    localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_arm_m, r_arm_s;
    logic [3:0]       r_sens_m, r_sens_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_zone;
    logic             r_led;
    logic             r_siren;

    state_t           w_next_state;
    logic             w_state_chg;
    logic             w_tick;
    logic             w_expire;
    logic [CNT_W-1:0] w_next_cnt;
    logic [3:0]       w_next_zone;
    logic             w_next_led;
    logic             w_next_siren;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_arm_m  <= 1'b0;
            r_arm_s  <= 1'b0;
            r_sens_m <= '0;
            r_sens_s <= '0;
        end else begin
            r_arm_m  <= arm;
            r_arm_s  <= r_arm_m;
            r_sens_m <= sensor;
            r_sens_s <= r_sens_m;
        end
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clear (w_state_chg),
        .o_tick  (w_tick)
    );

    assign w_expire    = w_tick && (r_cnt == CNT_ONE);
    assign w_state_chg = (w_next_state != r_state);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_DISARMED;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Disarm has priority over every other transition.
    always_comb begin
        w_next_state = r_state;
        if (!r_arm_s) begin
            w_next_state = ST_DISARMED;
        end else begin
            case (r_state)
                ST_DISARMED: w_next_state = ST_EXIT;
                ST_EXIT:     if (w_expire) w_next_state = ST_ARMED;
                ST_ARMED:    if (r_sens_s != 4'd0) w_next_state = ST_ENTRY;
                ST_ENTRY:    if (w_expire) w_next_state = ST_SIREN;
                ST_SIREN:    if (w_expire) w_next_state = ST_ARMED;
                default:     w_next_state = ST_DISARMED;
            endcase
        end
    end

    always_comb begin
        w_next_cnt   = r_cnt;
        w_next_zone  = r_zone;
        w_next_led   = r_led;
        w_next_siren = (w_next_state == ST_SIREN);
        if (w_next_state == ST_DISARMED) begin
            w_next_cnt  = '0;
            w_next_zone = '0;
            w_next_led  = 1'b0;
        end else begin
            if ((r_state == ST_ARMED) || (r_state == ST_ENTRY) || (r_state == ST_SIREN)) begin
                w_next_zone = r_zone | r_sens_s;
            end
            if (w_state_chg) begin
                w_next_led = 1'b1;
                case (w_next_state)
                    ST_EXIT:  w_next_cnt = EXIT_LD;
                    ST_ENTRY: w_next_cnt = ENTRY_LD;
                    ST_SIREN: w_next_cnt = SIREN_LD;
                    default:  w_next_cnt = '0;
                endcase
            end else if (w_tick) begin
                if (is_timed(r_state) && (r_cnt > CNT_ONE)) begin
                    w_next_cnt = r_cnt - CNT_ONE;
                end
                if (is_blink(r_state)) begin
                    w_next_led = ~r_led;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_zone  <= '0;
            r_led   <= 1'b0;
            r_siren <= 1'b0;
        end else begin
            r_cnt   <= w_next_cnt;
            r_zone  <= w_next_zone;
            r_led   <= w_next_led;
            r_siren <= w_next_siren;
        end
    end

    assign siren      = r_siren;
    assign led        = r_led;
    assign state_code = r_state;
    assign remaining  = r_cnt;
    assign zone       = r_zone;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed scenarios plus randomized switching,
// checked every cycle against an elapsed-time model of the sequencer.
module tb_alarm_sequencer;

    localparam int TD    = 4;
    localparam int EXT   = 3;
    localparam int ENT   = 2;
    localparam int SIR   = 3;

    logic       clk;
    logic       reset;
    logic       arm;
    logic [3:0] sensor;
    logic       siren;
    logic       led;
    logic [2:0] state_code;
    logic [7:0] remaining;
    logic [3:0] zone;

    int total = 0;
    int bad   = 0;

    alarm_sequencer #(
        .TICK_DIV    (TD),
        .EXIT_TICKS  (EXT),
        .ENTRY_TICKS (ENT),
        .SIREN_TICKS (SIR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .sensor     (sensor),
        .siren      (siren),
        .led        (led),
        .state_code (state_code),
        .remaining  (remaining),
        .zone       (zone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: states 0..4, time spent in the current state, and sticky zone.
    bit       m_valid = 1'b0;
    bit       m_a1, m_a2;
    bit [3:0] m_s1, m_s2;
    int       m_st, m_age;
    bit [3:0] m_zone;

    function automatic int dur_of(input int st);
        case (st)
            1:       return EXT * TD;
            3:       return ENT * TD;
            4:       return SIR * TD;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        int nst;
        if (reset) begin
            m_a1 = 0; m_a2 = 0; m_s1 = 0; m_s2 = 0;
            m_st = 0; m_age = 0; m_zone = 0;
            m_valid = 1'b1;
        end else begin
            nst = m_st;
            if (!m_a2) begin
                nst = 0;
                m_zone = 0;
            end else begin
                if (m_st >= 2) m_zone = m_zone | m_s2;
                case (m_st)
                    0: nst = 1;
                    1: if (m_age + 1 == dur_of(1)) nst = 2;
                    2: if (m_s2 != 0) nst = 3;
                    3: if (m_age + 1 == dur_of(3)) nst = 4;
                    4: if (m_age + 1 == dur_of(4)) nst = 2;
                    default: nst = 0;
                endcase
            end
            m_age = (nst != m_st) ? 0 : m_age + 1;
            m_st  = nst;
            m_a2 = m_a1; m_a1 = arm;
            m_s2 = m_s1; m_s1 = sensor;
        end
    end

    function automatic int exp_rem();
        case (m_st)
            1:       return EXT - m_age / TD;
            3:       return ENT - m_age / TD;
            4:       return SIR - m_age / TD;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_led();
        case (m_st)
            1, 3:    return ((m_age / TD) % 2 == 0) ? 1 : 0;
            2, 4:    return 1;
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_state", state_code, m_st);
            chk("model_siren", siren, (m_st == 4) ? 1 : 0);
            chk("model_remaining", remaining, exp_rem());
            chk("model_led", led, exp_led());
            chk("model_zone", zone, m_zone);
        end
    end

    task automatic wait_state(input int s, input int lim);
        int n = 0;
        while (state_code != s && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("wait_state", state_code, s);
    endtask

    initial begin
        int n;
        reset = 1'b1; arm = 1'b1; sensor = 4'hF;

        // Reset held with inputs active: everything stays zero.
        repeat (3) begin
            @(negedge clk);
            chk("rst_state", state_code, 0);
            chk("rst_siren", siren, 0);
            chk("rst_led", led, 0);
            chk("rst_remaining", remaining, 0);
            chk("rst_zone", zone, 0);
        end
        reset = 1'b0; sensor = 4'h0;
        repeat (2) begin
            @(negedge clk);
            chk("latency_state", state_code, 0);
        end
        @(negedge clk);
        chk("exit_entry_state", state_code, 1);
        chk("exit_entry_rem", remaining, 3);

        // EXIT countdown and blinking; a sensor pulse here is ignored.
        n = 0;
        while (state_code == 1 && n < 40) begin
            chk("exit_rem", remaining, 3 - n / 4);
            chk("exit_led", led, ((n / 4) % 2 == 0) ? 1 : 0);
            if (n == 0) sensor = 4'b0100;
            if (n == 2) sensor = 4'b0000;
            n++;
            @(negedge clk);
        end
        chk("exit_len", n, 12);
        chk("armed_state", state_code, 2);
        chk("armed_zone", zone, 0);
        chk("armed_rem", remaining, 0);

        // Sensor in ARMED: ENTRY for 8 cycles, SIREN for 12, back to ARMED.
        repeat (2) @(negedge clk);
        sensor = 4'b0100;
        wait_state(3, 10);
        chk("entry_zone", zone, 4'b0100);
        chk("entry_rem", remaining, 2);
        sensor = 4'b0000;
        n = 0;
        while (state_code == 3 && n < 40) begin
            chk("entry_siren_off", siren, 0);
            n++;
            @(negedge clk);
        end
        chk("entry_len", n, 8);
        chk("siren_state", state_code, 4);
        n = 0;
        while (siren == 1'b1 && n < 40) begin
            chk("siren_rem", remaining, 3 - n / 4);
            chk("siren_led", led, 1);
            n++;
            @(negedge clk);
        end
        chk("siren_len", n, 12);
        chk("rearm_state", state_code, 2);
        chk("rearm_zone", zone, 4'b0100);

        // Disarm in the middle of ENTRY.
        sensor = 4'b0001;
        wait_state(3, 10);
        sensor = 4'b0000;
        repeat (2) @(negedge clk);
        arm = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("disarm_siren", siren, 0);
            if (k < 3) chk("disarm_pending", state_code, 3);
        end
        chk("disarm_state", state_code, 0);
        chk("disarm_zone", zone, 0);
        chk("disarm_rem", remaining, 0);

        // Sensor rise and disarm on the same edge while ARMED.
        arm = 1'b1;
        wait_state(2, 40);
        @(negedge clk);
        sensor = 4'b0010; arm = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("race_no_entry", (state_code == 3) ? 1 : 0, 0);
        end
        chk("race_state", state_code, 0);
        sensor = 4'b0000;

        // Reset in the middle of SIREN.
        arm = 1'b1;
        wait_state(2, 40);
        sensor = 4'b1000;
        wait_state(4, 40);
        sensor = 4'b0000;
        chk("pre_reset_siren", siren, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_siren", siren, 0);
        chk("midrst_state", state_code, 0);
        chk("midrst_zone", zone, 0);
        reset = 1'b0;

        // Randomized switching, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            int r;
            @(negedge clk);
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 149) == 0) arm = ~arm;
            r = $urandom_range(0, 9);
            if (r == 0) sensor = 4'($urandom);
            else if (r < 4) sensor = 4'b0000;
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Timed arming/alarm controller that sits directly downstream of the switch-level sensor and enable inputs, and beside the existing sensor-count display path. It turns the raw enable switch and four sensor lines into a timed state sequence: exit delay, armed, entry delay, siren, and re-arm. It drives the siren output, a status LED, a state code and a countdown value that the display stage consumes.

## Interface
Parameters:
- TICK_DIV, 100_000_000: clock cycles per timing tick (1 s at 100 MHz); ≥2
- EXIT_TICKS, 10: exit-delay length in ticks; 1..255
- ENTRY_TICKS, 5: entry-delay length in ticks; 1..255
- SIREN_TICKS, 60: siren-on length in ticks; 1..255

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- arm  in  1  enable switch (sw[4]), asynchronous level
- sensor  in  4  sensor switches (sw[3:0]), asynchronous levels, 1 = tripped
- siren  out  1  alarm output, 1 only in SIREN
- led  out  1  status LED
- state_code  out  3  0 DISARMED, 1 EXIT, 2 ARMED, 3 ENTRY, 4 SIREN
- remaining  out  8  ticks left in the current timed state
- zone  out  4  sticky record of the sensors that caused or joined the alarm

## Operation
- arm and sensor each pass through a 2-flop synchronizer. All FSM decisions use the synchronized values arm_s and sensor_s.
- Any state with arm_s=0 goes to DISARMED on the next edge. This has priority over every other transition. On that edge, zone and the countdown clear.
- DISARMED with arm_s=1: go to EXIT and load countdown=EXIT_TICKS.
- EXIT: sensor_s is ignored. On a tick, if countdown==1, go to ARMED; otherwise decrement.
- ARMED with sensor_s≠0: go to ENTRY, load ENTRY_TICKS, and set zone |= sensor_s.
- ENTRY: zone |= sensor_s every cycle. On a tick, if countdown==1, go to SIREN and load SIREN_TICKS; otherwise decrement.
- SIREN: zone |= sensor_s every cycle. On a tick, if countdown==1, go to ARMED; otherwise decrement. zone is kept. A sensor still high re-enters ENTRY on the next edge.
- remaining = countdown in EXIT, ENTRY and SIREN; 0 in DISARMED and ARMED.
- led: 0 in DISARMED, 1 in ARMED and SIREN. In EXIT and ENTRY it is set to 1 on state entry and toggles on every tick.
- siren, led, state_code, remaining and zone are all registered outputs.

## Timing
- Reset values: state DISARMED, siren=0, led=0, state_code=0, remaining=0, zone=0, synchronizers=0, prescaler=0. Reset mid-operation takes effect on the next edge and overrides any pending transition.
- Input latency: an input change sampled at edge k appears in arm_s/sensor_s after edge k+1. The state change is visible after edge k+2, i.e. 3 edges from the first sampling edge.
- Tick: the prescaler clears on the edge that enters any new state. A tick is asserted in the cycle where prescaler==TICK_DIV-1. The prescaler free-runs in DISARMED and ARMED, but ticks are unused there.
- A timed state of N ticks lasts exactly N×TICK_DIV cycles. remaining steps N, N-1, …, 1, each value held for TICK_DIV cycles.
- Countdown arithmetic is 8-bit unsigned. It never decrements below 1 and never wraps.
- Simultaneous events:
  - arm_s=0 together with a sensor or a tick: DISARMED wins.
  - Sensor rising in the same cycle as ENTRY expiry: the sensor is ORed into zone and the state still goes to SIREN.

## Structure
- Shared package alarm_pkg holds:
  - state enum and its 3-bit encodings (values above)
  - countdown width constant, CNT_W=8
- One sub-module, tick_gen:
  - prescaler with clear input and tick output
  - parameter TICK_DIV
- Synchronizers and FSM are inline in alarm_sequencer.

## Test plan
All scenarios use TICK_DIV=4, EXIT_TICKS=3, ENTRY_TICKS=2, SIREN_TICKS=3.
- Reset held 3 cycles with arm=1, sensor=4'hF -> all outputs 0, state_code=0 throughout. State_code=1 appears 3 edges after reset drops.
- arm 0→1 -> state_code=1 and remaining=3 after 3 edges. remaining reads 3,2,1 for 4 cycles each. state_code=2 after exactly 12 cycles in EXIT. led toggles at each tick.
- sensor=4'b0100 pulsed during EXIT -> ignored. The same sensor asserted in ARMED -> ENTRY with zone=4'b0100. After 8 cycles, SIREN with siren=1 for 12 cycles, then ARMED with zone still 4'b0100.
- arm dropped mid-ENTRY -> state_code=0 three edges later, siren never asserts, zone=0.
- In ARMED, sensor rises and arm falls on the same edge -> DISARMED directly, state_code never equals 3.
- Reset asserted mid-SIREN -> siren=0, state_code=0, zone=0 after the next edge.
